// File: rtl/rx_sched.sv
// Receive-transaction scheduler: arms the USB receiver for one packet, bounds each
// phase with a shared timer, aborts and retries on failure, reports one status pulse.
module rx_sched #(
  parameter int TIMEOUT_CYC = 255,
  parameter int PKT_CYC     = 128,
  parameter int EOP_CYC     = 4,
  parameter int MAX_TRIES   = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rx_start,
  input  logic                           rx_is_hs,
  input  logic                           rx_cancel,
  output logic                           busy,
  output logic                           rx_done,
  output logic [1:0]                     rx_status,
  output logic [$clog2(MAX_TRIES+1)-1:0] tries,
  output logic                           receive_data,
  output logic                           receive_hshake,
  output logic                           abort,
  input  logic                           got_sync,
  input  logic                           end_rc_nrzi,
  input  logic                           EOP_error,
  input  logic                           rc_dpdm_wait
);

  localparam int TW     = $clog2(MAX_TRIES + 1);
  localparam int MAX_AB = (TIMEOUT_CYC > PKT_CYC) ? TIMEOUT_CYC : PKT_CYC;
  localparam int MAXC   = (MAX_AB > EOP_CYC) ? MAX_AB : EOP_CYC;
  localparam int TMR_W  = $clog2(MAXC);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_ERROR   = 2'b10;
  localparam logic [1:0] ST_CANCEL  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_RECV  = 3'd2,
    S_EOPW  = 3'd3,
    S_ABORT = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t             state_r, state_s;
  logic [TMR_W-1:0]   tmr_r, tmr_s;
  logic               is_hs_r, is_hs_s;
  logic [TW-1:0]      tries_r, tries_s;
  logic [1:0]         code_r, code_s;
  logic [1:0]         status_r, status_s;
  logic               busy_r, done_r, abort_r, rdata_r, rhs_r;
  logic               rx_on_s;

  // Next-state, timer, attempt counter and recorded failure code.
  always_comb begin
    state_s  = state_r;
    is_hs_s  = is_hs_r;
    tries_s  = tries_r;
    code_s   = code_r;
    status_s = status_r;
    case (state_r)
      S_IDLE: begin
        if (rx_start) begin
          state_s = S_ARM;
          is_hs_s = rx_is_hs;
          tries_s = TW'(1);
          code_s  = ST_OK;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ARM: begin
        if (rx_cancel) begin
          state_s = S_ABORT;
          code_s  = ST_CANCEL;
        end else if (EOP_error) begin
          state_s = S_ABORT;
          code_s  = ST_ERROR;
        end else if (got_sync) begin
          state_s = S_RECV;
        end else if (tmr_r == TMR_W'(TIMEOUT_CYC - 1)) begin
          state_s = S_ABORT;
          code_s  = ST_TIMEOUT;
        end else begin
          state_s = S_ARM;
        end
      end
      S_RECV: begin
        if (rx_cancel) begin
          state_s = S_ABORT;
          code_s  = ST_CANCEL;
        end else if (EOP_error) begin
          state_s = S_ABORT;
          code_s  = ST_ERROR;
        end else if (end_rc_nrzi) begin
          state_s = S_EOPW;
        end else if (tmr_r == TMR_W'(PKT_CYC - 1)) begin
          state_s = S_ABORT;
          code_s  = ST_ERROR;
        end else begin
          state_s = S_RECV;
        end
      end
      S_EOPW: begin
        if (rx_cancel) begin
          state_s = S_ABORT;
          code_s  = ST_CANCEL;
        end else if (EOP_error) begin
          state_s = S_ABORT;
          code_s  = ST_ERROR;
        end else if (rc_dpdm_wait) begin
          state_s = S_DONE;
          code_s  = ST_OK;
        end else if (tmr_r == TMR_W'(EOP_CYC - 1)) begin
          state_s = S_ABORT;
          code_s  = ST_ERROR;
        end else begin
          state_s = S_EOPW;
        end
      end
      S_ABORT: begin
        if (rx_cancel) begin
          state_s = S_DONE;
          code_s  = ST_CANCEL;
        end else if ((tries_r < TW'(MAX_TRIES)) && (code_r != ST_CANCEL)) begin
          state_s = S_ARM;
          tries_s = tries_r + TW'(1);
        end else begin
          state_s = S_DONE;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase

    // Status is cleared on acceptance and published only as DONE is entered.
    if ((state_r == S_IDLE) && rx_start) begin
      status_s = ST_OK;
    end else if ((state_s == S_DONE) && (state_r != S_DONE)) begin
      status_s = code_s;
    end else begin
      status_s = status_r;
    end

    if (state_s != state_r) begin
      tmr_s = {TMR_W{1'b0}};
    end else if ((state_r == S_ARM) || (state_r == S_RECV) || (state_r == S_EOPW)) begin
      tmr_s = tmr_r + TMR_W'(1);
    end else begin
      tmr_s = {TMR_W{1'b0}};
    end

    rx_on_s = (state_s == S_ARM) || (state_s == S_RECV);
  end

  // State and output registers; outputs are decoded from the next state so they
  // line up with the registered state while staying flop-driven.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= S_IDLE;
      tmr_r    <= {TMR_W{1'b0}};
      is_hs_r  <= 1'b0;
      tries_r  <= {TW{1'b0}};
      code_r   <= ST_OK;
      status_r <= ST_OK;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      abort_r  <= 1'b0;
      rdata_r  <= 1'b0;
      rhs_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      tmr_r    <= tmr_s;
      is_hs_r  <= is_hs_s;
      tries_r  <= tries_s;
      code_r   <= code_s;
      status_r <= status_s;
      busy_r   <= (state_s != S_IDLE);
      done_r   <= (state_s == S_DONE);
      abort_r  <= (state_s == S_ABORT);
      rdata_r  <= rx_on_s & ~is_hs_s;
      rhs_r    <= rx_on_s & is_hs_s;
    end
  end

  assign busy           = busy_r;
  assign rx_done        = done_r;
  assign abort          = abort_r;
  assign receive_data   = rdata_r;
  assign receive_hshake = rhs_r;
  assign rx_status      = status_r;
  assign tries          = tries_r;

endmodule

// File: tb/tb_rx_sched.sv
// Self-checking bench for rx_sched: table of per-cycle stimulus masks with expected
// abort/receive patterns, plus a scoreboard checked on every rx_done pulse.
module tb_rx_sched;
  localparam int TO = 8;
  localparam int PK = 16;
  localparam int EO = 4;
  localparam int MT = 3;

  logic       clk = 1'b0;
  logic       rst, rx_start, rx_is_hs, rx_cancel;
  logic       busy, rx_done, receive_data, receive_hshake, abort;
  logic [1:0] rx_status;
  logic [1:0] tries;
  logic       got_sync, end_rc_nrzi, EOP_error, rc_dpdm_wait;

  always #5 clk = ~clk;

  rx_sched #(.TIMEOUT_CYC(TO), .PKT_CYC(PK), .EOP_CYC(EO), .MAX_TRIES(MT)) dut (
    .clk(clk), .rst(rst), .rx_start(rx_start), .rx_is_hs(rx_is_hs), .rx_cancel(rx_cancel),
    .busy(busy), .rx_done(rx_done), .rx_status(rx_status), .tries(tries),
    .receive_data(receive_data), .receive_hshake(receive_hshake), .abort(abort),
    .got_sync(got_sync), .end_rc_nrzi(end_rc_nrzi), .EOP_error(EOP_error),
    .rc_dpdm_wait(rc_dpdm_wait)
  );

  typedef struct {
    logic        is_hs;
    logic [63:0] start_v, sync_v, end_v, wait_v, err_v, cancel_v, recv_v, abort_v;
    int          done_cyc;
    logic [1:0]  status;
    logic [1:0]  tries;
  } vec_t;

  typedef struct {
    logic [1:0] status;
    logic [1:0] tries;
    int         done_cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;
  int   checks = 0;
  int   failures = 0;
  int   cur_cyc = 0;
  int   done_cnt = 0;
  vec_t vt[9];

  function automatic logic [63:0] rng(int lo, int hi);
    logic [63:0] m;
    m = 64'd0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] b(int i);
    return rng(i, i);
  endfunction

  function automatic vec_t mk(logic hs, logic [63:0] st, logic [63:0] sy, logic [63:0] en,
                              logic [63:0] wt, logic [63:0] er, logic [63:0] ca,
                              logic [63:0] rv, logic [63:0] ab, int dc,
                              logic [1:0] s, logic [1:0] t);
    vec_t v;
    v.is_hs = hs; v.start_v = st; v.sync_v = sy; v.end_v = en; v.wait_v = wt;
    v.err_v = er; v.cancel_v = ca; v.recv_v = rv; v.abort_v = ab;
    v.done_cyc = dc; v.status = s; v.tries = t;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cur_cyc);
    end
  endtask

  // Scoreboard: every rx_done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rx_done === 1'b1) begin
      done_cnt++;
      if (abort === 1'b1) check("abort_with_done", 64'd1, 64'd0);
      if (sb_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        sb_e = sb_q.pop_front();
        check("done_cycle", 64'(cur_cyc), 64'(sb_e.done_cyc));
        check("status", 64'(rx_status), 64'(sb_e.status));
        check("tries", 64'(tries), 64'(sb_e.tries));
      end
    end
  end

  task automatic idle_inputs();
    rx_start = 1'b0; rx_cancel = 1'b0; got_sync = 1'b0;
    end_rc_nrzi = 1'b0; EOP_error = 1'b0; rc_dpdm_wait = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [63:0] ab_obs;
    int          bad;
    exp_t        e;
    ab_obs = 64'd0;
    bad = 0;
    e.status = v.status; e.tries = v.tries; e.done_cyc = v.done_cyc;
    sb_q.push_back(e);
    cur_cyc = 0;
    idle_inputs();
    rx_start = 1'b1;
    rx_is_hs = v.is_hs;
    @(posedge clk); #1;
    for (int c = 1; c <= v.done_cyc + 2; c++) begin
      cur_cyc      = c;
      rx_start     = v.start_v[c];
      rx_is_hs     = ~v.is_hs;
      got_sync     = v.sync_v[c];
      end_rc_nrzi  = v.end_v[c];
      rc_dpdm_wait = v.wait_v[c];
      EOP_error    = v.err_v[c];
      rx_cancel    = v.cancel_v[c];
      @(negedge clk);
      ab_obs[c] = abort;
      if (receive_hshake !== (v.recv_v[c] & v.is_hs)) bad++;
      if (receive_data !== (v.recv_v[c] & ~v.is_hs)) bad++;
      if (busy !== (c <= v.done_cyc)) bad++;
      @(posedge clk); #1;
    end
    idle_inputs();
    check($sformatf("abort_pattern[%0d]", idx), ab_obs, v.abort_v);
    check($sformatf("recv_busy_pattern[%0d]", idx), 64'(bad), 64'd0);
    check($sformatf("done_seen[%0d]", idx), 64'(sb_q.size()), 64'd0);
    sb_q.delete();
  endtask

  initial begin
    int bad;
    int d0;
    rst = 1'b1;
    rx_is_hs = 1'b0;
    idle_inputs();
    vt[0] = mk(1'b1, 64'd0, b(3), b(12), b(14), 64'd0, 64'd0, rng(1, 12), 64'd0, 15, 2'b00, 2'd1);
    vt[1] = mk(1'b0, 64'd0, b(1), b(5), b(6), 64'd0, 64'd0, rng(1, 5), 64'd0, 7, 2'b00, 2'd1);
    vt[2] = mk(1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0,
               rng(1, 8) | rng(10, 17) | rng(19, 26), b(9) | b(18) | b(27), 28, 2'b01, 2'd3);
    vt[3] = mk(1'b1, 64'd0, b(3) | b(10), b(15), b(17), b(6), 64'd0,
               rng(1, 6) | rng(8, 15), b(7), 18, 2'b00, 2'd2);
    vt[4] = mk(1'b0, 64'd0, b(8), b(10), b(11), 64'd0, 64'd0, rng(1, 10), 64'd0, 12, 2'b00, 2'd1);
    vt[5] = mk(1'b1, 64'd0, b(2), 64'd0, 64'd0, b(5), b(5), rng(1, 5), b(6), 7, 2'b11, 2'd1);
    vt[6] = mk(1'b0, 64'd0, b(1) | b(19) | b(26), b(20), 64'd0, b(27), 64'd0,
               rng(1, 17) | rng(19, 20) | rng(26, 27), b(18) | b(25) | b(28), 29, 2'b10, 2'd3);
    vt[7] = mk(1'b1, 64'd0, 64'd0, 64'd0, 64'd0, b(2), b(3), rng(1, 2), b(3), 4, 2'b11, 2'd1);
    vt[8] = mk(1'b1, b(2) | b(8), b(4), b(6), b(7), 64'd0, 64'd0, rng(1, 6), 64'd0, 8, 2'b00, 2'd1);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_outputs",
          64'({busy, rx_done, receive_data, receive_hshake, abort, tries, rx_status}), 64'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) run_vec(i, vt[i]);

    // Reset for two cycles while a data packet is in RECV.
    bad = 0;
    d0 = done_cnt;
    rx_is_hs = 1'b0;
    rx_start = 1'b1;
    @(posedge clk); #1;
    rx_start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      cur_cyc  = c;
      got_sync = (c == 2);
      rst      = (c == 5) || (c == 6);
      @(negedge clk);
      if (abort !== 1'b0) bad++;
      if (c == 4 && receive_data !== 1'b1) bad++;
      if (c >= 6 && {busy, rx_done, receive_data, receive_hshake, abort, tries, rx_status} !== 9'd0)
        bad++;
      @(posedge clk); #1;
    end
    rst = 1'b0;
    idle_inputs();
    check("mid_reset_outputs", 64'(bad), 64'd0);
    check("mid_reset_no_done", 64'(done_cnt - d0), 64'd0);

    run_vec(9, vt[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
